// File: rtl/div_share_pkg.sv
// Shared types and constants for the time-shared divider controller.
// Holds the FSM state encoding, the owner-index width helper and the
// reset constants. Used by div_share_ctrl (and, with DIV_ZERO_CHECK_EN
// defined, by its divide-by-zero bypass path).
package div_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_N_REQ = 2;

  // Owner index width; never below one bit so a single requester still has a field.
  function automatic int owner_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned OWNER_W = owner_width(DEF_N_REQ);

  localparam state_t RST_STATE = IDLE;

endpackage

// File: rtl/div_share_ctrl_rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   valid   : request vector
//   rr_last : index of the most recent winner
//   grant   : one-hot winner (zero when nothing is valid)
//   idx     : binary index of the winner (zero when nothing is valid)
// The scan starts one past rr_last and wraps around.
module rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDX_W-1:0] rr_last,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int  k;
    logic found;
    k     = 0;
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      k = (int'(rr_last) + 1 + i) % int'(N_REQ);
      if (!found && valid[k]) begin
        grant[k] = 1'b1;
        idx      = IDX_W'(k);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/division.sv
// Combinational unsigned restoring array divider.
// Ports:
//   a, b : dividend, divisor (WIDTH bits)
//   q, r : quotient, remainder (WIDTH bits)
// With b == 0 the array naturally yields q = all ones and r = a.
module division #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  logic [WIDTH:0] rem;

  // One shift/compare/subtract row per quotient bit, MSB first.
  always_comb begin
    rem = '0;
    q   = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      rem = {rem[WIDTH-1:0], a[i]};
      if (rem >= {1'b0, b}) begin
        rem  = rem - {1'b0, b};
        q[i] = 1'b1;
      end
    end
  end

  assign r = rem[WIDTH-1:0];

endmodule

// File: rtl/div_share_ctrl.sv
// Time-shares one combinational divider between N_REQ requesters.
// Ports:
//   clk_i, rstn_i          : clock, synchronous active-low reset
//   req_valid_i/req_ready_o: per-requester request handshake (ready is
//                            combinational, one-hot or zero, IDLE only)
//   req_a_i, req_b_i       : packed operands, requester k at [k*WIDTH +: WIDTH]
//   rsp_valid_o            : one-hot response valid to the owner
//   rsp_ready_i            : per-requester response accept (owner bit only)
//   rsp_q_o, rsp_r_o       : shared quotient / remainder bus
//   rsp_dz_o               : divide-by-zero flag for the current response
//   busy_o                 : high whenever the FSM is not in IDLE
// Optional: DIV_ZERO_CHECK_EN makes B==0 bypass CALC and answer with
// Q=all ones, R=A, dz=1 one cycle after accept.
module div_share_ctrl
  import div_share_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned N_REQ = DEF_N_REQ
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic [N_REQ*WIDTH-1:0] req_a_i,
  input  logic [N_REQ*WIDTH-1:0] req_b_i,
  output logic [N_REQ-1:0]       rsp_valid_o,
  input  logic [N_REQ-1:0]       rsp_ready_i,
  output logic [WIDTH-1:0]       rsp_q_o,
  output logic [WIDTH-1:0]       rsp_r_o,
  output logic                   rsp_dz_o,
  output logic                   busy_o
);

  localparam int unsigned OWNER_BITS = owner_width(N_REQ);
  localparam logic [OWNER_BITS-1:0] RR_RST = OWNER_BITS'(N_REQ - 1);

  state_t                state;
  logic [OWNER_BITS-1:0] rr_last;
  logic [OWNER_BITS-1:0] owner;
  logic [OWNER_BITS-1:0] grant_idx;
  logic [N_REQ-1:0]      grant;
  logic [N_REQ-1:0]      owner_oh;
  logic [WIDTH-1:0]      op_a;
  logic [WIDTH-1:0]      op_b;
  logic [WIDTH-1:0]      res_q;
  logic [WIDTH-1:0]      res_r;
  logic [WIDTH-1:0]      div_q;
  logic [WIDTH-1:0]      div_r;
  logic [WIDTH-1:0]      sel_a;
  logic [WIDTH-1:0]      sel_b;
  logic                  owner_done;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (OWNER_BITS)
  ) u_arb (
    .valid   (req_valid_i),
    .rr_last (rr_last),
    .grant   (grant),
    .idx     (grant_idx)
  );

  division #(
    .WIDTH (WIDTH)
  ) u_div (
    .a (op_a),
    .b (op_b),
    .q (div_q),
    .r (div_r)
  );

  // Grants are only offered while idle; requesters hold valid otherwise.
  assign req_ready_o = (state == IDLE) ? grant : '0;

  // Operand mux for the arbitration winner.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (OWNER_BITS'(k) == grant_idx) begin
        sel_a = req_a_i[k*int'(WIDTH) +: WIDTH];
        sel_b = req_b_i[k*int'(WIDTH) +: WIDTH];
      end
    end
  end

  // Owner decode; response-ready bits of other requesters are masked off.
  always_comb begin
    owner_oh = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      owner_oh[k] = (OWNER_BITS'(k) == owner);
    end
  end

  assign owner_done = |(rsp_ready_i & owner_oh);

  assign rsp_q_o = res_q;
  assign rsp_r_o = res_r;

  // Control FSM with registered response/busy outputs.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state       <= RST_STATE;
      rr_last     <= RR_RST;
      owner       <= '0;
      op_a        <= '0;
      op_b        <= '0;
      res_q       <= '0;
      res_r       <= '0;
      rsp_valid_o <= '0;
      rsp_dz_o    <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_ready_o) begin
            op_a    <= sel_a;
            op_b    <= sel_b;
            owner   <= grant_idx;
            rr_last <= grant_idx;
            busy_o  <= 1'b1;
`ifdef DIV_ZERO_CHECK_EN
            if (sel_b == '0) begin
              // Zero divisor answers immediately with a fixed result.
              res_q       <= '1;
              res_r       <= sel_a;
              rsp_dz_o    <= 1'b1;
              rsp_valid_o <= grant;
              state       <= RESP;
            end else begin
              state <= CALC;
            end
`else
            state <= CALC;
`endif
          end
        end
        CALC: begin
          res_q       <= div_q;
          res_r       <= div_r;
          rsp_valid_o <= owner_oh;
          rsp_dz_o    <= 1'b0;
          state       <= RESP;
        end
        RESP: begin
          if (owner_done) begin
            rsp_valid_o <= '0;
            rsp_dz_o    <= 1'b0;
            busy_o      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          rsp_valid_o <= '0;
          rsp_dz_o    <= 1'b0;
          busy_o      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Scoreboard bench for div_share_ctrl (WIDTH=4, N_REQ=2).
// Stimulus pushes hand-computed responses into a queue; a negedge
// monitor pops and compares on every response handshake.
module tb_div_share_ctrl;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned N_REQ = 2;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       rsp_valid;
  logic [N_REQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]       rsp_q;
  logic [WIDTH-1:0]       rsp_r;
  logic                   rsp_dz;
  logic                   busy;

  typedef struct {
    int         owner;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
    bit         chk_qr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  div_share_ctrl #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_q_o     (rsp_q),
    .rsp_r_o     (rsp_r),
    .rsp_dz_o    (rsp_dz),
    .busy_o      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [3:0] a, input logic [3:0] b);
    req_valid[k]             = 1'b1;
    req_a[k*WIDTH +: WIDTH]  = a;
    req_b[k*WIDTH +: WIDTH]  = b;
  endtask

  task automatic push(input int owner, input logic [3:0] q, input logic [3:0] r,
                      input logic dz, input bit chk_qr);
    exp_t e;
    e.owner  = owner;
    e.q      = q;
    e.r      = r;
    e.dz     = dz;
    e.chk_qr = chk_qr;
    sb.push_back(e);
  endtask

  // Waits (bounded) for a negedge with a grant visible; returns its index.
  task automatic wait_grant(output int k);
    int n;
    n = 0;
    k = -1;
    while (k < 0 && n < 50) begin
      @(negedge clk);
      for (int i = 0; i < int'(N_REQ); i++) if (req_ready[i]) k = i;
      n++;
    end
    if (k < 0) begin
      errors++;
      checks++;
      $display("FAIL grant_timeout: got none expected a grant within 50 cycles");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "grant timeout");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", sb.size(), 0);
    step();
  endtask

  // Response monitor: compares on each owner handshake.
  always @(negedge clk) begin
    if (rstn === 1'b1 && (rsp_valid & rsp_ready) != '0) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_owner", 32'(rsp_valid), 32'(1) << e.owner);
        chk("rsp_dz", 32'(rsp_dz), 32'(e.dz));
        if (e.chk_qr) begin
          chk("rsp_q", 32'(rsp_q), 32'(e.q));
          chk("rsp_r", 32'(rsp_r), 32'(e.r));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end expected finish before 200000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  logic [3:0] op_a[6];
  logic [3:0] op_b[6];
  logic [3:0] op_q[6];
  logic [3:0] op_r[6];

  initial begin
    int k;
    int n;
    rstn      = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '0;
    step();
    step();
    // Reset state.
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_q", 32'(rsp_q), 0);
    chk("rst_r", 32'(rsp_r), 0);
    chk("rst_dz", 32'(rsp_dz), 0);
    chk("rst_busy", 32'(busy), 0);
    step();
    rstn = 1'b1;

    // Single op: 13/3 = 4 r 1.
    set_req(0, 4'd13, 4'd3);
    rsp_ready = 2'b11;
    push(0, 4'd4, 4'd1, 1'b0, 1'b1);
    @(negedge clk);
    chk("single_req_ready", 32'(req_ready), 32'b01);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("single_calc_valid", 32'(rsp_valid), 0);
    chk("single_calc_busy", 32'(busy), 1);
    @(negedge clk);
    chk("single_resp_valid", 32'(rsp_valid), 32'b01);
    chk("single_resp_busy", 32'(busy), 1);
    @(negedge clk);
    chk("single_after_busy", 32'(busy), 0);
    chk("single_after_valid", 32'(rsp_valid), 0);
    step();

    // Contention after reset: req0 wins first.
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    set_req(0, 4'd9, 4'd2);
    set_req(1, 4'd15, 4'd4);
    push(0, 4'd4, 4'd1, 1'b0, 1'b1);
    push(1, 4'd3, 4'd3, 1'b0, 1'b1);
    for (int j = 0; j < 2; j++) begin
      wait_grant(k);
      chk("contend_grant", k, j);
      step();
      req_valid[k] = 1'b0;
    end
    drain();
    chk("contend_rr_last", 32'(dut.rr_last), 1);

    // Fairness with a 3-cycle response stall on op 2.
    op_a = '{4'd14, 4'd11, 4'd15, 4'd6, 4'd12, 4'd15};
    op_b = '{4'd5,  4'd3,  4'd1,  4'd7, 4'd4,  4'd15};
    op_q = '{4'd2,  4'd3,  4'd15, 4'd0, 4'd3,  4'd1};
    op_r = '{4'd4,  4'd2,  4'd0,  4'd6, 4'd0,  4'd0};
    for (int j = 0; j < 6; j++) push(j % 2, op_q[j], op_r[j], 1'b0, 1'b1);
    set_req(0, op_a[0], op_b[0]);
    set_req(1, op_a[1], op_b[1]);
    rsp_ready = 2'b11;
    for (int j = 0; j < 6; j++) begin
      wait_grant(k);
      chk("fair_grant", k, j % 2);
      step();
      if (j + 2 < 6) set_req(k, op_a[j+2], op_b[j+2]);
      else req_valid[k] = 1'b0;
      if (j == 2) begin
        rsp_ready = 2'b00;
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          chk("stall_valid", 32'(rsp_valid), 32'b01);
          chk("stall_q", 32'(rsp_q), 15);
          chk("stall_r", 32'(rsp_r), 0);
          chk("stall_req_ready", 32'(req_ready), 0);
        end
        step();
        rsp_ready = 2'b11;
      end
    end
    drain();

    // Wrong-ready: only the owner's ready bit completes the response.
    set_req(1, 4'd10, 4'd3);
    push(1, 4'd3, 4'd1, 1'b0, 1'b1);
    rsp_ready = 2'b01;
    wait_grant(k);
    chk("wrong_grant", k, 1);
    step();
    req_valid = '0;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("wrong_hold_valid", 32'(rsp_valid), 32'b10);
      chk("wrong_hold_busy", 32'(busy), 1);
    end
    step();
    rsp_ready = 2'b10;
    drain();
    @(negedge clk);
    chk("wrong_done_busy", 32'(busy), 0);
    step();

    // Divide by zero: 7/0.
    rsp_ready = 2'b11;
    set_req(0, 4'd7, 4'd0);
`ifdef DIV_ZERO_CHECK_EN
    push(0, 4'd15, 4'd7, 1'b1, 1'b1);
`else
    push(0, 4'd0, 4'd0, 1'b0, 1'b0);
`endif
    wait_grant(k);
    chk("dz_grant", k, 0);
    step();
    req_valid = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rsp_valid == '0 && n < 10);
`ifdef DIV_ZERO_CHECK_EN
    chk("dz_latency", n, 1);
`else
    chk("dz_latency", n, 2);
`endif
    drain();

    // Reset during CALC drops the transaction.
    set_req(0, 4'd9, 4'd3);
    wait_grant(k);
    step();
    req_valid = '0;
    rstn      = 1'b0;
    step();
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 32'(rsp_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_q", 32'(rsp_q), 0);
    chk("midrst_r", 32'(rsp_r), 0);
    chk("midrst_dz", 32'(rsp_dz), 0);
    chk("midrst_req_ready", 32'(req_ready), 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("midrst_no_rsp", 32'(rsp_valid), 0);
    end
    step();
    set_req(0, 4'd8, 4'd3);
    set_req(1, 4'd5, 4'd2);
    push(0, 4'd2, 4'd2, 1'b0, 1'b1);
    push(1, 4'd2, 4'd1, 1'b0, 1'b1);
    for (int j = 0; j < 2; j++) begin
      wait_grant(k);
      chk("postrst_grant", k, j);
      step();
      req_valid[k] = 1'b0;
    end
    drain();

    chk("final_sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
Time-shares one combinational array divider (the existing `division` module) between N_REQ requesters.
- Round-robin arbitration over per-requester valid/ready request channels.
- Operands are registered into the divider, and the result is registered out.
- Response data is broadcast; a one-hot valid marks the owning requester.
- Sits between the arithmetic-unit clients and the divider, in place of per-client dividers.

Parameters:
WIDTH, 4, operand/quotient/remainder width; passed to the divider.
N_REQ, 2, number of requesters (2..8).

Ports:
clk_i  in  1  clock
rstn_i  in  1  synchronous active-low reset
req_valid_i  in  N_REQ  per-requester request valid
req_ready_o  out  N_REQ  per-requester accept; one-hot or zero
req_a_i  in  N_REQ*WIDTH  dividends; requester k at [k*WIDTH +: WIDTH]
req_b_i  in  N_REQ*WIDTH  divisors, same packing
rsp_valid_o  out  N_REQ  one-hot response valid to the owning requester
rsp_ready_i  in  N_REQ  per-requester response accept
rsp_q_o  out  WIDTH  quotient (shared bus)
rsp_r_o  out  WIDTH  remainder (shared bus)
rsp_dz_o  out  1  divide-by-zero flag for the current response
busy_o  out  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, CALC, RESP. Reset (rstn_i low at a clock edge) gives:
  - state=IDLE, rr_last=N_REQ-1, all outputs 0.
  - Operand and result registers are cleared to 0.
- IDLE arbitration:
  - Candidate scan starts at (rr_last+1) mod N_REQ and wraps; the first k with req_valid_i[k]=1 wins.
  - req_ready_o[k]=1 for the winner only; this is combinational from req_valid_i and rr_last.
  - No valid request gives req_ready_o=0.
- Accept: in IDLE, on req_valid_i[k]&req_ready_o[k] at the edge:
  - Capture A,B into op_a/op_b and set owner=k, rr_last=k.
  - Go to CALC.
- CALC (one cycle): the divider output from op_a/op_b is registered into res_q/res_r; go to RESP.
- RESP:
  - rsp_valid_o[owner]=1; rsp_q_o/rsp_r_o are driven from the result registers and held stable.
  - On rsp_ready_i[owner]=1 at the edge, go to IDLE.
  - rsp_ready_i bits of non-owners are ignored.
- Latency and throughput:
  - Response is visible 2 cycles after the accept edge.
  - No new accept until the cycle after the response handshake completes.
  - Back-to-back throughput is one op per 3 cycles when rsp_ready is held high.
- req_ready_o=0 in CALC and RESP, so requests are held by their requesters (valid must stay asserted until accepted).
- Reset in CALC or RESP: the transaction is dropped, rsp_valid_o=0 on the next cycle, and no response is ever issued for it.
- Fairness: with all requesters continuously valid, grants cycle 0,1,..,N_REQ-1,0,...
- Arithmetic: unsigned. rsp_q_o*B + rsp_r_o = A and rsp_r_o < B whenever B != 0.
- rsp_dz_o=0 outside RESP.

Optional Feature:
DIV_ZERO_CHECK_EN
- Defined:
  - On accept with B==0, the FSM skips CALC and goes directly to RESP.
  - Result is forced to rsp_q_o = all ones, rsp_r_o = A, rsp_dz_o=1.
  - Response latency is 1 cycle.
- Not defined:
  - B==0 follows the normal CALC path and rsp_dz_o is tied 0.
  - Q/R are the raw divider output and are unspecified; the bench does not check them.

Decomposition:
- Package div_share_pkg holds:
  - state_t enum {IDLE, CALC, RESP};
  - localparam OWNER_W = $clog2(N_REQ) (min 1);
  - reset constants.
- One natural sub-module, rr_arbiter: combinational round-robin pick from (valid vector, rr_last) to a one-hot grant plus index.
- The existing `division` module is instantiated once as the datapath.

Test Plan:
- Single op (WIDTH=4): req0 A=13 B=3, rsp_ready_i held 1:
  - req_ready_o[0] high in the request cycle;
  - rsp_valid_o=01 two cycles after accept with Q=4 R=1, dz=0;
  - busy_o high for 2 cycles.
- Contention after reset: req0 (A=9,B=2) and req1 (A=15,B=4) valid together:
  - req0 is granted first (Q=4 R=1), then req1 (Q=3 R=3);
  - rr_last ends at 1.
- Fairness and stall:
  - Both requesters continuously valid for 6 ops: grant order 0,1,0,1,0,1.
  - Hold rsp_ready_i low 3 cycles in RESP: rsp_valid_o and Q/R stay stable, req_ready_o stays 00.
- Wrong-ready: owner=1 in RESP while rsp_ready_i=01 (non-owner) → FSM stays in RESP; it completes only when bit 1 rises.
- Divide-by-zero with DIV_ZERO_CHECK_EN defined, A=7 B=0 → response 1 cycle after accept with Q=15, R=7, dz=1. Without the macro, the response comes after 2 cycles with dz=0.
- Reset mid-operation: rstn_i low for 1 cycle during CALC → next cycle IDLE with all outputs 0 and no response. A new request then gets arbitration starting from req0.
